smiley_collision_ctrl: RTL and testbench

- Closes the loop around the smiley motion generator. It watches per-pixel drawing requests during each frame and classifies overlaps of the smiley with the screen border and with obstacles.
- At each startOfFrame it produces the motion generator's control inputs: X_direction, toggleY and the collision re-centre pulse.
- Sits between the object drawers / pixel counter and the smiley motion block.

---
 rtl/smiley_collision_ctrl.sv | 165 ++++++++++++++++
 tb/tb_smiley_collision_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smiley_collision_ctrl.sv
// Classifies smiley overlaps with border walls and obstacles during a frame and,
// at each startOfFrame, drives the motion block's direction, Y-toggle and re-centre controls.
module smiley_collision_ctrl #(
  parameter int BORDER_W       = 4,
  parameter int H_MAX          = 639,
  parameter int V_MAX          = 479,
  parameter int TOGGLE_LEN     = 3,
  parameter int HOLDOFF_FRAMES = 4,
  parameter int STUCK_FRAMES   = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        smileyDR,
  input  logic        borderDR,
  input  logic        obstacleDR,
  output logic        X_direction,
  output logic        toggleY,
  output logic        collision,
  output logic [15:0] hitCount
);

  // state   | meaning
  // COLLECT | accumulate sticky hit flags until startOfFrame
  // EVAL    | one clock: classify the closed frame and issue responses
  // RESPOND | hold toggleY high for TOGGLE_LEN clocks
  typedef enum logic [1:0] {COLLECT, EVAL, RESPOND} state_t;

  localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
  localparam int TW = (TOGGLE_LEN > 1) ? $clog2(TOGGLE_LEN) : 1;
  localparam int SW = $clog2(STUCK_FRAMES + 1);
  localparam logic [10:0] LO_LIM    = 11'(BORDER_W);
  localparam logic [10:0] RIGHT_LIM = 11'(H_MAX - BORDER_W);
  localparam logic [10:0] BOT_LIM   = 11'(V_MAX - BORDER_W);

  state_t          state, state_nxt;
  logic            hit_top, hit_bot, hit_left, hit_right, hit_obs;
  logic            hit_top_nxt, hit_bot_nxt, hit_left_nxt, hit_right_nxt, hit_obs_nxt;
  logic [HW-1:0]   h_hold, h_hold_nxt, v_hold, v_hold_nxt;
  logic [SW-1:0]   stuck_cnt, stuck_cnt_nxt;
  logic [TW-1:0]   resp_cnt, resp_cnt_nxt;
  logic [15:0]     hit_count, hit_count_nxt;
  logic            x_dir_nxt, toggle_nxt, collision_nxt;
  logic [1:0]      add;
  logic [16:0]     hit_sum;
  logic            hz, vt, any_border, stuck_trip, wall_hit;

  assign hz         = hit_left | hit_right;
  assign vt         = hit_top | hit_bot;
  assign any_border = hz | vt;
  assign stuck_trip = any_border && (stuck_cnt >= SW'(STUCK_FRAMES - 1));
  assign wall_hit   = smileyDR && borderDR;
  assign hitCount   = hit_count;

  always_comb begin
    state_nxt     = state;
    hit_top_nxt   = hit_top;
    hit_bot_nxt   = hit_bot;
    hit_left_nxt  = hit_left;
    hit_right_nxt = hit_right;
    hit_obs_nxt   = hit_obs;
    h_hold_nxt    = h_hold;
    v_hold_nxt    = v_hold;
    stuck_cnt_nxt = stuck_cnt;
    resp_cnt_nxt  = resp_cnt;
    x_dir_nxt     = X_direction;
    toggle_nxt    = toggleY;
    collision_nxt = 1'b0;
    add           = 2'd0;

    case (state)
      COLLECT: begin
        if (wall_hit && (pixelY <= LO_LIM))    hit_top_nxt   = 1'b1;
        if (wall_hit && (pixelY >= BOT_LIM))   hit_bot_nxt   = 1'b1;
        if (wall_hit && (pixelX <= LO_LIM))    hit_left_nxt  = 1'b1;
        if (wall_hit && (pixelX >= RIGHT_LIM)) hit_right_nxt = 1'b1;
        if (smileyDR && obstacleDR)            hit_obs_nxt   = 1'b1;
        if (startOfFrame) state_nxt = EVAL;
      end
      EVAL: begin
        state_nxt     = COLLECT;
        hit_top_nxt   = 1'b0;
        hit_bot_nxt   = 1'b0;
        hit_left_nxt  = 1'b0;
        hit_right_nxt = 1'b0;
        hit_obs_nxt   = 1'b0;
        if (hit_obs || stuck_trip) begin
          // re-centre overrides any wall response and restarts all hold-offs
          collision_nxt = 1'b1;
          h_hold_nxt    = '0;
          v_hold_nxt    = '0;
          stuck_cnt_nxt = '0;
          add           = 2'd1;
        end else begin
          if (hz && (h_hold == '0)) begin
            x_dir_nxt  = ~X_direction;
            h_hold_nxt = HW'(HOLDOFF_FRAMES);
            add        = add + 2'd1;
          end else if (h_hold != '0) begin
            h_hold_nxt = h_hold - HW'(1);
          end
          if (vt && (v_hold == '0)) begin
            v_hold_nxt   = HW'(HOLDOFF_FRAMES);
            add          = add + 2'd1;
            toggle_nxt   = 1'b1;
            resp_cnt_nxt = TW'(TOGGLE_LEN - 1);
            state_nxt    = RESPOND;
          end else if (v_hold != '0) begin
            v_hold_nxt = v_hold - HW'(1);
          end
          stuck_cnt_nxt = any_border ? stuck_cnt + SW'(1) : '0;
        end
      end
      RESPOND: begin
        if (resp_cnt == '0) begin
          toggle_nxt = 1'b0;
          state_nxt  = COLLECT;
        end else begin
          resp_cnt_nxt = resp_cnt - TW'(1);
        end
      end
      default: state_nxt = COLLECT;
    endcase

    hit_sum       = {1'b0, hit_count} + 17'(add);
    hit_count_nxt = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state       <= COLLECT;
      hit_top     <= 1'b0;
      hit_bot     <= 1'b0;
      hit_left    <= 1'b0;
      hit_right   <= 1'b0;
      hit_obs     <= 1'b0;
      h_hold      <= '0;
      v_hold      <= '0;
      stuck_cnt   <= '0;
      resp_cnt    <= '0;
      hit_count   <= '0;
      X_direction <= 1'b1;
      toggleY     <= 1'b0;
      collision   <= 1'b0;
    end else begin
      state       <= state_nxt;
      hit_top     <= hit_top_nxt;
      hit_bot     <= hit_bot_nxt;
      hit_left    <= hit_left_nxt;
      hit_right   <= hit_right_nxt;
      hit_obs     <= hit_obs_nxt;
      h_hold      <= h_hold_nxt;
      v_hold      <= v_hold_nxt;
      stuck_cnt   <= stuck_cnt_nxt;
      resp_cnt    <= resp_cnt_nxt;
      hit_count   <= hit_count_nxt;
      X_direction <= x_dir_nxt;
      toggleY     <= toggle_nxt;
      collision   <= collision_nxt;
    end
  end

endmodule

// File: tb/tb_smiley_collision_ctrl.sv
// Bench for smiley_collision_ctrl: a frame-level timeline model checked every clock,
// plus hand-computed expectations for each directed scenario.
module tb_smiley_collision_ctrl;
  localparam int BW = 4, HM = 639, VM = 479, TL = 3, HO = 4, SF = 8;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic        smileyDR = 1'b0, borderDR = 1'b0, obstacleDR = 1'b0;
  logic        X_direction, toggleY, collision;
  logic [15:0] hitCount;

  smiley_collision_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .smileyDR(smileyDR), .borderDR(borderDR), .obstacleDR(obstacleDR),
    .X_direction(X_direction), .toggleY(toggleY), .collision(collision),
    .hitCount(hitCount)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: per-frame rules applied to a cycle timeline
  int cyc = 0, busy_end = 0, upd_cyc = 0;
  bit pend = 0, vresp = 0, p_coll = 0;
  bit f_top = 0, f_bot = 0, f_left = 0, f_right = 0, f_obs = 0;
  int m_x = 1, m_hh = 0, m_vh = 0, m_stuck = 0, m_hits = 0;
  int p_x = 1, p_hits = 0;
  int exp_x = 1, exp_t = 0, exp_c = 0, exp_h = 0;
  int preload_seq = 0, preload_seen = 0;

  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (resetN) begin
      m_x = 1; m_hh = 0; m_vh = 0; m_stuck = 0; m_hits = 0;
      f_top = 0; f_bot = 0; f_left = 0; f_right = 0; f_obs = 0;
      pend = 0; vresp = 0;
      exp_x = 1; exp_t = 0; exp_c = 0; exp_h = 0;
      busy_end = cyc;
    end else begin
      if (preload_seq != preload_seen) begin
        preload_seen = preload_seq;
        m_hits = 65534;
        exp_h  = 65534;
      end
      exp_c = 0;
      if (pend && cyc == upd_cyc) begin
        exp_x = p_x; exp_h = p_hits; exp_c = int'(p_coll); pend = 0;
      end
      exp_t = (vresp && cyc >= upd_cyc && cyc < upd_cyc + TL) ? 1 : 0;
      if (cyc > busy_end) begin
        if (smileyDR && borderDR) begin
          if (int'(pixelY) <= BW)      f_top   = 1;
          if (int'(pixelY) >= VM - BW) f_bot   = 1;
          if (int'(pixelX) <= BW)      f_left  = 1;
          if (int'(pixelX) >= HM - BW) f_right = 1;
        end
        if (smileyDR && obstacleDR) f_obs = 1;
        if (startOfFrame) begin
          automatic bit hz = f_left | f_right;
          automatic bit vt = f_top | f_bot;
          automatic int n = 0;
          p_coll = 0; vresp = 0;
          if (f_obs || ((hz || vt) && m_stuck + 1 >= SF)) begin
            p_coll = 1; m_hh = 0; m_vh = 0; m_stuck = 0; n = 1;
          end else begin
            if (hz && m_hh == 0) begin m_x = 1 - m_x; m_hh = HO; n++; end
            else if (m_hh > 0) m_hh--;
            if (vt && m_vh == 0) begin vresp = 1; m_vh = HO; n++; end
            else if (m_vh > 0) m_vh--;
            m_stuck = (hz || vt) ? m_stuck + 1 : 0;
          end
          m_hits = (m_hits + n > 65535) ? 65535 : m_hits + n;
          p_x = m_x; p_hits = m_hits; pend = 1;
          upd_cyc  = cyc + 1;
          busy_end = cyc + 1 + (vresp ? TL : 0);
          f_top = 0; f_bot = 0; f_left = 0; f_right = 0; f_obs = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #2;
    check("X_direction", int'(X_direction), exp_x);
    check("toggleY",     int'(toggleY),     exp_t);
    check("collision",   int'(collision),   exp_c);
    check("hitCount",    int'(hitCount),    exp_h);
  end

  task automatic tick(input int x, input int y, input bit s, input bit b, input bit o, input bit sof);
    @(negedge clk);
    pixelX = 11'(x); pixelY = 11'(y);
    smileyDR = s; borderDR = b; obstacleDR = o; startOfFrame = sof;
  endtask

  task automatic hit(input int x, input int y, input bit b, input bit o);
    tick(x, y, 1'b1, b, o, 1'b0);
  endtask

  // pulse startOfFrame, then sample 7 clocks starting at the edge that sees it
  task automatic end_frame(output logic [6:0] tb, output logic [6:0] cb);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #3;
      tb[i] = toggleY; cb[i] = collision;
      @(negedge clk);
      smileyDR = 1'b0; borderDR = 1'b0; obstacleDR = 1'b0; startOfFrame = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); resetN = 1'b1;
    smileyDR = 1'b0; borderDR = 1'b0; obstacleDR = 1'b0; startOfFrame = 1'b0;
    @(negedge clk);
    @(negedge clk); resetN = 1'b0;
  endtask

  task automatic preload_ffe();
    @(negedge clk);
    force dut.hit_count = 16'hFFFE;
    preload_seq++;
    @(negedge clk);
    @(negedge clk);
    release dut.hit_count;
  endtask

  initial begin
    logic [6:0] tb, cb;
    logic [8:0] xs, cs;

    do_reset();
    @(posedge clk); #3;
    check("rst_x", int'(X_direction), 1);
    check("rst_toggle", int'(toggleY), 0);
    check("rst_coll", int'(collision), 0);
    check("rst_hits", int'(hitCount), 0);

    // left wall with hold-off
    xs = '0;
    for (int f = 0; f < 6; f++) begin
      hit(2, 200, 1'b1, 1'b0);
      end_frame(tb, cb);
      xs[f] = X_direction;
      if (f == 0) check("left_f1_hits", int'(hitCount), 1);
    end
    check("left_x_hist", int'(xs[5:0]), 6'b100000);
    check("left_f6_hits", int'(hitCount), 2);

    // top wall toggleY window
    do_reset();
    hit(300, 1, 1'b1, 1'b0);
    end_frame(tb, cb);
    check("top_toggle_win", int'(tb), 7'b0001110);
    check("top_x", int'(X_direction), 1);
    check("top_hits", int'(hitCount), 1);

    // bottom hit; sof and hits during EVAL/RESPOND are ignored
    do_reset();
    hit(300, 476, 1'b1, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(2, 200, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(300, 200, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end_frame(tb, cb);
    check("busy_ignore_toggle", int'(tb), 0);
    check("busy_ignore_x", int'(X_direction), 1);
    check("busy_ignore_hits", int'(hitCount), 1);

    // threshold boundaries
    do_reset();
    hit(5, 200, 1'b1, 1'b0);
    hit(634, 200, 1'b1, 1'b0);
    hit(300, 5, 1'b1, 1'b0);
    hit(300, 474, 1'b1, 1'b0);
    hit(2, 200, 1'b0, 1'b0);
    tick(2, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    end_frame(tb, cb);
    check("bound_out_hits", int'(hitCount), 0);
    check("bound_out_toggle", int'(tb), 0);
    hit(4, 200, 1'b1, 1'b0);
    hit(300, 475, 1'b1, 1'b0);
    end_frame(tb, cb);
    check("bound_in_x", int'(X_direction), 0);
    check("bound_in_hits", int'(hitCount), 2);
    check("bound_in_toggle", int'(tb), 7'b0001110);

    // corner plus obstacle: collision wins
    do_reset();
    hit(638, 478, 1'b1, 1'b0);
    hit(300, 200, 1'b0, 1'b1);
    end_frame(tb, cb);
    check("corner_coll", int'(cb), 7'b0000010);
    check("corner_toggle", int'(tb), 0);
    check("corner_x", int'(X_direction), 1);
    check("corner_hits", int'(hitCount), 1);

    // stuck at the right wall for 9 frames
    do_reset();
    xs = '0; cs = '0;
    for (int f = 0; f < 9; f++) begin
      hit(637, 200, 1'b1, 1'b0);
      end_frame(tb, cb);
      xs[f] = X_direction;
      cs[f] = |cb;
    end
    check("stuck_coll_hist", int'(cs), 9'b010000000);
    check("stuck_x_hist", int'(xs), 9'b011100000);
    check("stuck_hits", int'(hitCount), 4);

    // saturation
    do_reset();
    preload_ffe();
    hit(300, 200, 1'b0, 1'b1);
    end_frame(tb, cb);
    check("sat_obs1", int'(hitCount), 65535);
    hit(300, 200, 1'b0, 1'b1);
    end_frame(tb, cb);
    check("sat_obs2", int'(hitCount), 65535);

    // +2 into saturation, then reset during RESPOND
    preload_ffe();
    hit(2, 200, 1'b1, 1'b0);
    hit(300, 1, 1'b1, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("sat_double_hits", int'(hitCount), 65535);
    check("respond_toggle", int'(toggleY), 1);
    resetN = 1'b1;
    @(posedge clk); #3;
    check("midrst_toggle", int'(toggleY), 0);
    check("midrst_hits", int'(hitCount), 0);
    check("midrst_x", int'(X_direction), 1);
    @(negedge clk); resetN = 1'b0;
    hit(2, 200, 1'b1, 1'b0);
    end_frame(tb, cb);
    check("post_rst_x", int'(X_direction), 0);
    check("post_rst_hits", int'(hitCount), 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
